tap_core: RTL and testbench

- Parametrised JTAG TAP: 16-state TAP FSM plus instruction register, bypass register, optional IDCODE register and TDO mux, in one block.
- Exports one-hot user data-register selects with capture/shift/update strobes, so user DRs (boundary scan, debug) attach without their own TAP decode.
- Sits directly behind the device JTAG pins.

---
 rtl/tap_core.sv | 210 +++++++++++++++++++++
 tb/tb_tap_core.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_core.sv
// tap_core: JTAG TAP controller with instruction register, bypass register,
// optional IDCODE register and one-hot user data-register channel selects.
// Optional feature macro: TAP_IDCODE_EN adds the 32-bit IDCODE register and
// makes it the instruction loaded out of reset. Without it, the reset
// instruction is all-ones (BYPASS) and OP_IDCODE decodes as BYPASS.
// State and shift registers update on rising TCK; TDO, INSTR, TAP_RST and the
// update strobe update on falling TCK. TRST is a synchronous active-low reset
// honoured on both edges.

module tap_core #(
    parameter int          IR_WIDTH   = 4,
    parameter int          NUM_USER   = 2,
    parameter int          USER_BASE  = 8,
    parameter int          OP_IDCODE  = 14,
    parameter logic [31:0] IDCODE_VAL = 32'h0BA00477
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          STATE,
    output logic [IR_WIDTH-1:0] INSTR,
    output logic [NUM_USER-1:0] USER_SEL,
    input  logic [NUM_USER-1:0] USER_TDO,
    output logic                CAPTUREDR,
    output logic                SHIFTDR,
    output logic                UPDATEDR,
    output logic                TAP_RST
);

    // Elaboration-time parameter sanity checks.
    if (IR_WIDTH < 2) begin : g_bad_ir_width
        $error("tap_core: IR_WIDTH must be at least 2");
    end
    if (NUM_USER < 1 || NUM_USER > 8) begin : g_bad_num_user
        $error("tap_core: NUM_USER must be in 1..8");
    end
    if (OP_IDCODE >= (1 << IR_WIDTH)) begin : g_bad_op_idcode
        $error("tap_core: OP_IDCODE does not fit in IR_WIDTH bits");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("tap_core: IDCODE_VAL bit 0 must be 1");
    end

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] INSTR_RST = IR_WIDTH'(OP_IDCODE);
`else
    localparam logic [IR_WIDTH-1:0] INSTR_RST = '1;
`endif

    tap_state_e          state;
    tap_state_e          state_next;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass;
    logic                sel_user;
    logic                dr_tdo;
    logic                tdo_next;
    logic                upd_flag;
`ifdef TAP_IDCODE_EN
    logic [31:0]         idcode_sr;
    logic                sel_idcode;
`endif

    assign STATE = state;

    // TAP state register; reset forces Test-Logic-Reset.
    always_ff @(posedge TCK) begin
        if (!TRST) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    // IEEE 1149.1 next-state decode on TMS.
    always_comb begin
        state_next = TLR;
        case (state)
            TLR:      state_next = TMS ? TLR      : RTI;
            RTI:      state_next = TMS ? SEL_DR   : RTI;
            SEL_DR:   state_next = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_next = TMS ? EX1_DR   : SH_DR;
            SH_DR:    state_next = TMS ? EX1_DR   : SH_DR;
            EX1_DR:   state_next = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_next = TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_next = TMS ? UPD_DR   : SH_DR;
            UPD_DR:   state_next = TMS ? SEL_DR   : RTI;
            SEL_IR:   state_next = TMS ? TLR      : CAP_IR;
            CAP_IR:   state_next = TMS ? EX1_IR   : SH_IR;
            SH_IR:    state_next = TMS ? EX1_IR   : SH_IR;
            EX1_IR:   state_next = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_next = TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_next = TMS ? UPD_IR   : SH_IR;
            UPD_IR:   state_next = TMS ? SEL_DR   : RTI;
            default:  state_next = TLR;
        endcase
    end

    // Instruction shift register: capture 0...01, shift right with TDI into the MSB.
    always_ff @(posedge TCK) begin
        if (!TRST) begin
            ir_shift <= '0;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_WIDTH'(1);
        end else if (state == SH_IR) begin
            ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        end
    end

    // Bypass bit: cleared on capture, follows TDI while shifting.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            if (state == CAP_DR) begin
                bypass <= 1'b0;
            end else if (state == SH_DR) begin
                bypass <= TDI;
            end
        end
    end

`ifdef TAP_IDCODE_EN
    // IDCODE register: loads the device ID on capture, shifts right while shifting.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            if (state == CAP_DR) begin
                idcode_sr <= IDCODE_VAL;
            end else if (state == SH_DR) begin
                idcode_sr <= {TDI, idcode_sr[31:1]};
            end
        end
    end
`endif

    // One-hot user channel decode from the active instruction.
    always_comb begin
        USER_SEL = '0;
        for (int k = 0; k < NUM_USER; k++) begin
            USER_SEL[k] = (INSTR == IR_WIDTH'(USER_BASE + k));
        end
    end

    assign sel_user = |USER_SEL;

`ifdef TAP_IDCODE_EN
    assign sel_idcode = !sel_user && (INSTR == IR_WIDTH'(OP_IDCODE));
    assign dr_tdo     = sel_user   ? |(USER_TDO & USER_SEL) :
                        sel_idcode ? idcode_sr[0]           : bypass;
`else
    assign dr_tdo     = sel_user ? |(USER_TDO & USER_SEL) : bypass;
`endif

    // Serial output selection for the current shift state.
    always_comb begin
        tdo_next = 1'b0;
        if (state == SH_IR) begin
            tdo_next = ir_shift[0];
        end else if (state == SH_DR) begin
            tdo_next = dr_tdo;
        end
    end

    assign CAPTUREDR = (state == CAP_DR) && sel_user;
    assign SHIFTDR   = (state == SH_DR)  && sel_user;
    // The flag is set on the falling edge in Update-DR; gating with the state
    // drops the strobe at the rising edge that leaves Update-DR.
    assign UPDATEDR  = upd_flag && (state == UPD_DR);

    // Falling-edge outputs: instruction, TDO, TDO enable, TAP reset and update flag.
    always_ff @(negedge TCK) begin
        if (!TRST) begin
            INSTR    <= INSTR_RST;
            TDO      <= 1'b0;
            TDO_EN   <= 1'b0;
            TAP_RST  <= 1'b0;
            upd_flag <= 1'b0;
        end else begin
            if (state == TLR) begin
                INSTR <= INSTR_RST;
            end else if (state == UPD_IR) begin
                INSTR <= ir_shift;
            end
            TDO      <= tdo_next;
            TDO_EN   <= (state == SH_IR) || (state == SH_DR);
            TAP_RST  <= (state != TLR);
            upd_flag <= (state == UPD_DR) && sel_user;
        end
    end

endmodule

// File: tb/tb_tap_core.sv
// tb_tap_core: directed bench for tap_core with a TDO scoreboard queue.
// Honours TAP_IDCODE_EN so the same bench covers both builds.

module tb_tap_core;

    localparam logic [31:0] EXP_ID = 32'h0BA00477;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0] RST_INSTR = 4'hE;
`else
    localparam logic [3:0] RST_INSTR = 4'hF;
`endif

    logic       TCK = 1'b0;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic [1:0] USER_TDO;
    logic       TDO;
    logic       TDO_EN;
    logic [3:0] STATE;
    logic [3:0] INSTR;
    logic [1:0] USER_SEL;
    logic       CAPTUREDR;
    logic       SHIFTDR;
    logic       UPDATEDR;
    logic       TAP_RST;

    tap_core #(
        .IR_WIDTH  (4),
        .NUM_USER  (2),
        .USER_BASE (8),
        .OP_IDCODE (14),
        .IDCODE_VAL(EXP_ID)
    ) dut (
        .TCK      (TCK),
        .TRST     (TRST),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .TDO_EN   (TDO_EN),
        .STATE    (STATE),
        .INSTR    (INSTR),
        .USER_SEL (USER_SEL),
        .USER_TDO (USER_TDO),
        .CAPTUREDR(CAPTUREDR),
        .SHIFTDR  (SHIFTDR),
        .UPDATEDR (UPDATEDR),
        .TAP_RST  (TAP_RST)
    );

    always #5 TCK = ~TCK;

    int checks = 0;
    int errors = 0;
    int cap_cnt, shf_cnt, upd_cnt, upd_late;
    logic [3:0] s_state, s_instr_pos, s_instr;
    logic [1:0] s_usel;
    logic       s_tdo, s_en, s_taprst, s_upd;
    logic [3:0] cur_instr;
    logic       exp_q[$];

    // IEEE next states indexed by state code, for TMS=0 and TMS=1
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    // TMS paths from Test-Logic-Reset, bit i applied at step i
    logic [7:0] path_b [16] = '{8'h2A, 8'h0A, 8'h02, 8'h0A, 8'h06, 8'h1A, 8'h02, 8'h02,
                                8'h56, 8'h16, 8'h06, 8'h16, 8'h00, 8'h36, 8'h06, 8'h00};
    int         path_n [16] = '{6, 4, 4, 5, 3, 5, 3, 2, 7, 5, 5, 6, 1, 6, 4, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_tdo(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<empty queue>", tag, s_tdo);
        end else begin
            chk(tag, 32'(s_tdo), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic clr_cnt();
        cap_cnt = 0; shf_cnt = 0; upd_cnt = 0; upd_late = 0;
    endtask

    // One TCK cycle: drive, sample after the rising edge, then after the falling edge.
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK); #1;
        s_state     = STATE;
        s_instr_pos = INSTR;
        if (CAPTUREDR) cap_cnt++;
        if (SHIFTDR)   shf_cnt++;
        if (UPDATEDR)  upd_late++;
        @(negedge TCK); #1;
        s_tdo    = TDO;
        s_en     = TDO_EN;
        s_instr  = INSTR;
        s_usel   = USER_SEL;
        s_taprst = TAP_RST;
        s_upd    = UPDATEDR;
        if (UPDATEDR) upd_cnt++;
    endtask

    task automatic go_tlr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    endtask

    task automatic goto_state(input int s);
        go_tlr();
        for (int i = 0; i < path_n[s]; i++) step(path_b[s][i], 1'b0);
        chk("path_state", 32'(s_state), 32'(s));
    endtask

    // DR scan from RTI back to RTI. mode 0: bypass, 1: IDCODE, 2: user channel 1.
    task automatic scan_dr(input int n, input logic [31:0] tdi_v, input logic [31:0] u_v,
                           input int mode);
        logic e;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            USER_TDO = {u_v[k], ~u_v[k]};
            case (mode)
                0:       e = (k == 0) ? 1'b0 : tdi_v[k-1];
                1:       e = EXP_ID[k];
                default: e = u_v[k];
            endcase
            exp_q.push_back(e);
            step(1'b0, (k == 0) ? 1'b0 : tdi_v[k-1]);
            cmp_tdo("dr_tdo");
            chk("dr_tdo_en", 32'(s_en), 32'd1);
        end
        step(1'b1, tdi_v[n-1]);
        chk("ex1dr_tdo_en", 32'(s_en), 32'd0);
        step(1'b1, 1'b0);
        chk("upddr_state", 32'(s_state), 32'h5);
        step(1'b0, 1'b0);
        chk("rti_state", 32'(s_state), 32'hC);
    endtask

    // IR scan from RTI back to RTI with a bench-side IR model.
    task automatic scan_ir(input int n, input logic [3:0] tdi_v, input logic [1:0] exp_usel);
        logic [3:0] m;
        m = 4'b0001;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        if (n == 0) begin
            step(1'b1, 1'b0);
        end else begin
            for (int k = 0; k < n; k++) begin
                if (k > 0) m = {tdi_v[k-1], m[3:1]};
                exp_q.push_back(m[0]);
                step(1'b0, (k == 0) ? 1'b0 : tdi_v[k-1]);
                cmp_tdo("ir_tdo");
                chk("ir_tdo_en", 32'(s_en), 32'd1);
            end
            m = {tdi_v[n-1], m[3:1]};
            step(1'b1, tdi_v[n-1]);
        end
        chk("ex1ir_state", 32'(s_state), 32'h9);
        step(1'b1, 1'b0);
        chk("updir_instr_before_fall", 32'(s_instr_pos), 32'(cur_instr));
        chk("updir_instr", 32'(s_instr), 32'(m));
        chk("updir_user_sel", 32'(s_usel), 32'(exp_usel));
        cur_instr = m;
        step(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; USER_TDO = 2'b00;
        clr_cnt();

        // reset state
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_state", 32'(s_state), 32'hF);
        chk("rst_instr", 32'(s_instr), 32'(RST_INSTR));
        chk("rst_tdo", 32'(s_tdo), 32'd0);
        chk("rst_tdo_en", 32'(s_en), 32'd0);
        chk("rst_user_sel", 32'(s_usel), 32'd0);
        chk("rst_tap_rst", 32'(s_taprst), 32'd0);
        chk("rst_updatedr", 32'(s_upd), 32'd0);
        cur_instr = RST_INSTR;

        TRST = 1'b1;
        step(1'b0, 1'b0);
        chk("rti_after_rst", 32'(s_state), 32'hC);
        chk("tap_rst_high", 32'(s_taprst), 32'd1);

        // first DR scan after reset
        clr_cnt();
`ifdef TAP_IDCODE_EN
        scan_dr(32, 32'h0, 32'h0, 1);
`else
        scan_dr(32, 32'hA5C396E1, 32'h0, 0);
`endif
        chk("dr0_cap", 32'(cap_cnt), 32'd0);
        chk("dr0_upd", 32'(upd_cnt), 32'd0);

        // IR scan to user channel 1
        scan_ir(4, 4'h9, 2'b10);

        clr_cnt();
        scan_dr(8, 32'h5A, 32'hD2, 2);
        chk("user_cap_cnt", 32'(cap_cnt), 32'd1);
        chk("user_shf_cnt", 32'(shf_cnt), 32'd8);
        chk("user_upd_cnt", 32'(upd_cnt), 32'd1);
        chk("user_upd_late", 32'(upd_late), 32'd0);

        // reset in the middle of a user DR shift
        clr_cnt();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("mid_state_shdr", 32'(s_state), 32'h2);
        TRST = 1'b0;
        step(1'b0, 1'b0);
        chk("mid_rst_state", 32'(s_state), 32'hF);
        chk("mid_rst_instr", 32'(s_instr), 32'(RST_INSTR));
        chk("mid_rst_tdo_en", 32'(s_en), 32'd0);
        chk("mid_rst_tdo", 32'(s_tdo), 32'd0);
        chk("mid_rst_user_sel", 32'(s_usel), 32'd0);
        chk("mid_rst_tap_rst", 32'(s_taprst), 32'd0);
        TRST = 1'b1;
        cur_instr = RST_INSTR;
        step(1'b0, 1'b0);
        chk("mid_rst_no_upd", 32'(upd_cnt + upd_late), 32'd0);
        chk("mid_rst_rti", 32'(s_state), 32'hC);

        // non-user instruction: bypass with no strobes
        scan_ir(4, 4'h3, 2'b00);
        clr_cnt();
        scan_dr(8, 32'hB6, 32'h0, 0);
        chk("byp_strobes", 32'(cap_cnt + shf_cnt + upd_cnt), 32'd0);

        // pause in the middle of a bypass shift
        clr_cnt();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        exp_q.push_back(1'b0);
        step(1'b0, 1'b0);
        cmp_tdo("pause_tdo0");
        exp_q.push_back(1'b1);
        step(1'b0, 1'b1);
        cmp_tdo("pause_tdo1");
        step(1'b1, 1'b1);
        chk("ex1_tdo_en", 32'(s_en), 32'd0);
        chk("ex1_tdo", 32'(s_tdo), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("pause_state", 32'(s_state), 32'h3);
            chk("pause_tdo_en", 32'(s_en), 32'd0);
        end
        step(1'b1, 1'b0);
        chk("ex2_state", 32'(s_state), 32'h0);
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0);
        cmp_tdo("resume_tdo_held");
        exp_q.push_back(1'b0);
        step(1'b0, 1'b0);
        cmp_tdo("resume_tdo_next");
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("pause_strobes", 32'(cap_cnt + shf_cnt + upd_cnt), 32'd0);

        // capture then exit with no shifts loads 0001
        scan_ir(0, 4'h0, 2'b00);

        // Test-Logic-Reset forces the reset instruction
        scan_ir(4, 4'h9, 2'b10);
        go_tlr();
        chk("tlr_instr", 32'(s_instr), 32'(RST_INSTR));
        chk("tlr_user_sel", 32'(s_usel), 32'd0);
        chk("tlr_tap_rst", 32'(s_taprst), 32'd0);

        // every state: five TMS=1 reach TLR, and both IEEE transitions
        for (int s = 0; s < 16; s++) begin
            goto_state(s);
            go_tlr();
            chk("tms5_to_tlr", 32'(s_state), 32'hF);
            goto_state(s);
            step(1'b0, 1'b0);
            chk("trans_tms0", 32'(s_state), 32'(nxt0[s]));
            goto_state(s);
            step(1'b1, 1'b0);
            chk("trans_tms1", 32'(s_state), 32'(nxt1[s]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
